program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/seq_pkg.sv | 32 +++
 rtl/program_sequencer_prog_mem.sv | 54 +++++
 rtl/program_sequencer.sv | 176 +++++++++++++++++
 tb/tb_program_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the program sequencer: opcode values, the NOP word,
// FSM state encoding and default parameter values.
// ---------------------------------------------------------------------------
package seq_pkg;

  // Default parameter values for program_sequencer
  localparam int INSTR_WIDTH_DEF = 20;
  localparam int ADDR_BITS_DEF   = 5;
  localparam int EXEC_CYCLES_DEF = 3;

  // Width of the per-instruction EXEC cycle counter (EXEC_CYCLES is 1..15)
  localparam int CNT_W = 4;

  // Control opcodes (top nibble of the instruction word)
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Word presented to the CPU outside EXEC (default width)
  localparam logic [INSTR_WIDTH_DEF-1:0] NOP = {INSTR_WIDTH_DEF{1'b0}};

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

endpackage : seq_pkg

// File: rtl/program_sequencer_prog_mem.sv
// ---------------------------------------------------------------------------
// prog_mem
// Program storage: 2^ADDR_BITS words of INSTR_WIDTH bits, one synchronous
// write port and one synchronous read port. The read register doubles as the
// sequencer's instruction register, so it is cleared by reset; the array
// itself is never reset so the program survives a reset.
//
// Ports:
//   clk    - clock
//   rst    - asynchronous active-low reset (read register only)
//   wen    - write strobe
//   waddr  - write address
//   wdata  - write data
//   ren    - read enable (loads rdata from mem[raddr])
//   raddr  - read address
//   rdata  - registered read data
// ---------------------------------------------------------------------------
module prog_mem #(
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wen,
  input  logic [ADDR_BITS-1:0]   waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic                   ren,
  input  logic [ADDR_BITS-1:0]   raddr,
  output logic [INSTR_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [INSTR_WIDTH-1:0] mem_r [DEPTH];

  // Write port: storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (wen) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: registered read data, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= {INSTR_WIDTH{1'b0}};
    end else if (ren) begin
      rdata <= mem_r[raddr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule : prog_mem

// File: rtl/program_sequencer.sv
// ---------------------------------------------------------------------------
// program_sequencer
// Steps through a small program memory and hands each instruction to a CPU
// for EXEC_CYCLES cycles. Control opcodes (JMP, HALT) are consumed in DECODE
// and never shown to the CPU. All outputs are registered.
//
// Ports:
//   clk         - clock, all state changes on the rising edge
//   rst         - asynchronous active-low reset
//   start       - begin execution at address 0 (sampled in IDLE)
//   halt_req    - stop at the next instruction boundary
//   end_addr    - last program address (sampled on the last EXEC cycle)
//   prog_wen    - program write strobe (honoured only in IDLE)
//   prog_addr   - program write address
//   prog_data   - program write data
//   instruction - IR during EXEC, zero (NOP) otherwise
//   instr_valid - high exactly during EXEC cycles
//   pc          - program counter
//   busy        - high in every state except IDLE
//   done        - one-cycle pulse in DONE
//   prog_err    - sticky flag: program write attempted while busy
// ---------------------------------------------------------------------------
module program_sequencer
  import seq_pkg::*;
#(
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int EXEC_CYCLES = EXEC_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic [ADDR_BITS-1:0]   end_addr,
  input  logic                   prog_wen,
  input  logic [ADDR_BITS-1:0]   prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   busy,
  output logic                   done,
  output logic                   prog_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  seq_state_e             state_r;
  seq_state_e             state_s;
  logic [ADDR_BITS-1:0]   pc_r;
  logic [ADDR_BITS-1:0]   pc_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_s;
  logic [INSTR_WIDTH-1:0] ir_s;
  logic [3:0]             opcode_s;
  logic                   last_exec_s;
  logic                   mem_wen_s;
  logic                   fetch_s;

  logic [INSTR_WIDTH-1:0] instruction_r;
  logic                   instr_valid_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   prog_err_r;

  assign opcode_s    = ir_s[INSTR_WIDTH-1 -: 4];
  assign last_exec_s = (cnt_r == CNT_LAST);
  assign mem_wen_s   = prog_wen && (state_r == ST_IDLE);
  assign fetch_s     = (state_r == ST_FETCH);

  // Program memory; its read register is the instruction register
  prog_mem #(
    .ADDR_BITS   (ADDR_BITS),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_prog_mem (
    .clk   (clk),
    .rst   (rst),
    .wen   (mem_wen_s),
    .waddr (prog_addr),
    .wdata (prog_data),
    .ren   (fetch_s),
    .raddr (pc_r),
    .rdata (ir_s)
  );

  // Next-state, next-pc and EXEC counter logic
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          pc_s    = {ADDR_BITS{1'b0}};
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_DECODE;
      end
      ST_DECODE: begin
        if (halt_req || (opcode_s == OP_HALT)) begin
          state_s = ST_DONE;
        end else if (opcode_s == OP_JMP) begin
          pc_s    = ir_s[ADDR_BITS-1:0];
          state_s = ST_FETCH;
        end else begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (last_exec_s) begin
          if (halt_req || (pc_r == end_addr)) begin
            state_s = ST_DONE;
          end else begin
            // Natural modulo wrap: last address rolls over to 0
            pc_s    = pc_r + ADDR_BITS'(1'b1);
            state_s = ST_FETCH;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        pc_s    = {ADDR_BITS{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, pc and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      pc_r    <= {ADDR_BITS{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      cnt_r   <= cnt_s;
    end
  end

  // Output registers, decoded from the next state so they align with it;
  // in EXEC the IR is stable because it only loads during FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction_r <= {INSTR_WIDTH{1'b0}};
      instr_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      prog_err_r    <= 1'b0;
    end else begin
      instruction_r <= (state_s == ST_EXEC) ? ir_s : {INSTR_WIDTH{1'b0}};
      instr_valid_r <= (state_s == ST_EXEC);
      busy_r        <= (state_s != ST_IDLE);
      done_r        <= (state_s == ST_DONE);
      prog_err_r    <= prog_err_r | (prog_wen && (state_r != ST_IDLE));
    end
  end

  assign instruction = instruction_r;
  assign instr_valid = instr_valid_r;
  assign pc          = pc_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign prog_err    = prog_err_r;

endmodule : program_sequencer

// File: tb/tb_program_sequencer.sv
// ---------------------------------------------------------------------------
// tb_program_sequencer
// Self-checking bench for program_sequencer. Each scenario pushes the words
// it expects the CPU to receive into exp_q; a negedge monitor pops one word
// at the start of every EXEC window and checks window length and NOP output.
// ---------------------------------------------------------------------------
module tb_program_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic [4:0]  end_addr;
  logic        prog_wen;
  logic [4:0]  prog_addr;
  logic [19:0] prog_data;
  logic [19:0] instruction;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        busy;
  logic        done;
  logic        prog_err;

  int          total;
  int          bad;
  int          issue_cnt;
  logic [19:0] exp_q [$];
  logic [19:0] exp_w;
  logic        prev_valid;
  int          win_len;

  program_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt_req    (halt_req),
    .end_addr    (end_addr),
    .prog_wen    (prog_wen),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .prog_err    (prog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: one expected word per EXEC window
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
      win_len    = 0;
    end else begin
      if (instr_valid && !prev_valid) begin
        issue_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL issue_unexpected: got %h, no word expected", instruction);
        end else begin
          exp_w = exp_q.pop_front();
          if (instruction !== exp_w) begin
            bad++;
            $display("FAIL issue_word: got %h expected %h", instruction, exp_w);
          end
        end
        win_len = 1;
      end else if (instr_valid) begin
        win_len++;
      end else begin
        total++;
        if (instruction !== 20'h0_0000) begin
          bad++;
          $display("FAIL nop_when_invalid: got %h expected 00000", instruction);
        end
        if (prev_valid) begin
          total++;
          if (win_len != 3) begin
            bad++;
            $display("FAIL exec_window_len: got %0d expected 3", win_len);
          end
        end
      end
      prev_valid = instr_valid;
    end
  end

  task automatic load(input logic [4:0] a, input logic [19:0] d);
    prog_wen  = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(negedge clk);
    prog_wen  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 300) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({instruction, instr_valid, busy, done, prog_err} !== 24'h0 || pc !== 5'd0) begin
      bad++;
      $display("FAIL reset_state: got instr=%h v=%b busy=%b done=%b err=%b pc=%0d expected all 0",
               instruction, instr_valid, busy, done, prog_err, pc);
    end
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n;
    int first_v;
    int i0;
    load(5'd0, 20'h1_0203);
    load(5'd1, 20'h2_0405);
    end_addr = 5'd1;
    i0 = issue_cnt;
    exp_q.push_back(20'h1_0203);
    exp_q.push_back(20'h2_0405);
    pulse_start();
    n = 1;
    first_v = 0;
    while (!done && n < 100) begin
      if (instr_valid && first_v == 0) first_v = n;
      @(negedge clk);
      n++;
    end
    total++;
    if (first_v != 3) begin
      bad++;
      $display("FAIL basic_latency: got %0d expected 3 cycles after start", first_v);
    end
    total++;
    if (n + 1 != 12) begin
      bad++;
      $display("FAIL basic_start_to_done: got %0d expected 12", n + 1);
    end
    total++;
    if (pc !== 5'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_done_pc: got pc=%0d busy=%b expected pc=1 busy=1", pc, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
    total++;
    if (issue_cnt - i0 != 2 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL basic_issues: got %0d left=%0d expected 2 left=0", issue_cnt - i0, exp_q.size());
    end
  endtask

  task automatic test_jmp_halt();
    int  n;
    int  wins;
    bit  lp;
    bit  jmp_seen;
    int  i0;
    load(5'd0, 20'h1_0001);
    load(5'd1, 20'hE_0000);
    end_addr = 5'd31;
    i0 = issue_cnt;
    repeat (3) exp_q.push_back(20'h1_0001);
    pulse_start();
    n = 0; wins = 0; lp = 1'b0; jmp_seen = 1'b0;
    while (!done && n < 200) begin
      if (instruction[19:16] == 4'hE) jmp_seen = 1'b1;
      if (!instr_valid && lp) begin
        wins++;
        if (wins == 3) halt_req = 1'b1;
      end
      lp = instr_valid;
      @(negedge clk);
      n++;
    end
    halt_req = 1'b0;
    total++;
    if (!done || issue_cnt - i0 != 3 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL jmp_halt_issues: got done=%b issues=%0d expected done=1 issues=3", done, issue_cnt - i0);
    end
    total++;
    if (jmp_seen || pc !== 5'd1) begin
      bad++;
      $display("FAIL jmp_halt_pc: got jmp_seen=%b pc=%0d expected 0 and 1", jmp_seen, pc);
    end
    @(negedge clk);
  endtask

  task automatic test_halt_op();
    int cyc;
    bit ok;
    int i0;
    load(5'd0, 20'h3_0A0A);
    load(5'd1, 20'h4_0B0B);
    load(5'd2, 20'hF_0000);
    end_addr = 5'd31;
    i0 = issue_cnt;
    exp_q.push_back(20'h3_0A0A);
    exp_q.push_back(20'h4_0B0B);
    pulse_start();
    wait_done(cyc, ok);
    total++;
    if (!ok || pc !== 5'd2 || issue_cnt - i0 != 2) begin
      bad++;
      $display("FAIL halt_op: got done=%b pc=%0d issues=%0d expected 1 2 2", ok, pc, issue_cnt - i0);
    end
    @(negedge clk);
  endtask

  task automatic test_prog_err();
    int cyc;
    bit ok;
    int n;
    load(5'd0, 20'h1_0203);
    load(5'd1, 20'h2_0405);
    end_addr = 5'd1;
    exp_q.push_back(20'h1_0203);
    exp_q.push_back(20'h2_0405);
    pulse_start();
    n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (prog_err !== 1'b0) begin
      bad++;
      $display("FAIL prog_err_before: got %b expected 0", prog_err);
    end
    load(5'd0, 20'hA_BCDE);
    total++;
    if (prog_err !== 1'b1) begin
      bad++;
      $display("FAIL prog_err_set: got %b expected 1", prog_err);
    end
    wait_done(cyc, ok);
    @(negedge clk);
    total++;
    if (!ok || prog_err !== 1'b1) begin
      bad++;
      $display("FAIL prog_err_sticky: got done=%b err=%b expected 1 1", ok, prog_err);
    end
    // Rerun: monitor expects the original word at address 0
    exp_q.push_back(20'h1_0203);
    exp_q.push_back(20'h2_0405);
    pulse_start();
    wait_done(cyc, ok);
    @(negedge clk);
    total++;
    if (!ok || prog_err !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL prog_err_rerun: got done=%b err=%b left=%0d expected 1 1 0", ok, prog_err, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    int n;
    int i0;
    exp_q.push_back(20'h1_0203);
    exp_q.push_back(20'h2_0405);
    pulse_start();
    n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (instruction !== 20'h0 || instr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        prog_err !== 1'b0 || pc !== 5'd0) begin
      bad++;
      $display("FAIL reset_mid: got instr=%h v=%b busy=%b done=%b err=%b pc=%0d expected all 0",
               instruction, instr_valid, busy, done, prog_err, pc);
    end
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    i0 = issue_cnt;
    exp_q.push_back(20'h1_0203);
    exp_q.push_back(20'h2_0405);
    pulse_start();
    wait_done(cyc, ok);
    total++;
    if (!ok || pc !== 5'd1 || issue_cnt - i0 != 2) begin
      bad++;
      $display("FAIL reset_rerun: got done=%b pc=%0d issues=%0d expected 1 1 2", ok, pc, issue_cnt - i0);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int n;
    bit saw31;
    int i0;
    load(5'd0, 20'h5_0055);
    load(5'd1, 20'hE_001F);
    load(5'd31, 20'h6_0066);
    end_addr = 5'd2;
    i0 = issue_cnt;
    exp_q.push_back(20'h5_0055);
    exp_q.push_back(20'h6_0066);
    exp_q.push_back(20'h5_0055);
    pulse_start();
    n = 0;
    saw31 = 1'b0;
    while (!done && n < 200) begin
      if (pc == 5'd31) begin
        saw31    = 1'b1;
        end_addr = 5'd0;
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (!done || !saw31 || pc !== 5'd0) begin
      bad++;
      $display("FAIL wrap_pc: got done=%b saw31=%b pc=%0d expected 1 1 0", done, saw31, pc);
    end
    total++;
    if (issue_cnt - i0 != 3 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL wrap_issues: got %0d left=%0d expected 3 left=0", issue_cnt - i0, exp_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    issue_cnt  = 0;
    prev_valid = 1'b0;
    win_len    = 0;
    rst        = 1'b0;
    start      = 1'b0;
    halt_req   = 1'b0;
    end_addr   = 5'd0;
    prog_wen   = 1'b0;
    prog_addr  = 5'd0;
    prog_data  = 20'h0_0000;
    test_reset();
    test_basic();
    test_jmp_halt();
    test_halt_op();
    test_prog_err();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_program_sequencer
